// File: rtl/keypad_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_entry : debounced 0-9 + clear keypad front end feeding a BCD timer.
// Rev 1.0
// ---------------------------------------------------------------------------
module keypad_entry #(
    parameter int DEBOUNCE   = 4,
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [9:0] keys,
    input  logic       clear_key,
    input  logic       lock,
    output logic [3:0] data,
    output logic       loadn,
    output logic [1:0] digit_cnt,
    output logic       full,
    output logic       clr_pulse
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_DEBOUNCE     = 2'd1,
        S_LOAD         = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] C_DEB = 8'(DEBOUNCE);
    localparam logic [1:0] C_MAX = 2'(MAX_DIGITS);

    state_t      state_q;
    logic [10:0] meta_q;
    logic [10:0] pat_q;
    logic [10:0] cap_q;
    logic [7:0]  cnt_q;
    logic [3:0]  data_q;
    logic        loadn_q;
    logic [1:0]  digit_cnt_q;
    logic        full_q;
    logic        clr_pulse_q;

    logic        w_onehot;
    logic        w_digit_ok;
    logic        w_clear_ok;
    logic [3:0]  w_cap_idx;

    // Bit 10 of every pattern is the clear button, bits 9:0 the digit keys.
    assign w_onehot   = (pat_q[9:0] != 10'd0) &&
                        ((pat_q[9:0] & (pat_q[9:0] - 10'd1)) == 10'd0);
    assign w_digit_ok = w_onehot && !pat_q[10];
    assign w_clear_ok = pat_q[10] && (pat_q[9:0] == 10'd0);

    always_comb begin
        w_cap_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (cap_q[i]) begin
                w_cap_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            meta_q      <= '0;
            pat_q       <= '0;
            cap_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            loadn_q     <= 1'b1;
            digit_cnt_q <= '0;
            full_q      <= 1'b0;
            clr_pulse_q <= 1'b0;
        end else begin
            meta_q      <= {clear_key, keys};
            pat_q       <= meta_q;
            loadn_q     <= 1'b1;
            clr_pulse_q <= 1'b0;
            if (lock) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_digit_ok || w_clear_ok) begin
                            state_q <= S_DEBOUNCE;
                            cnt_q   <= 8'd1;
                            cap_q   <= pat_q;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (pat_q != cap_q) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q >= C_DEB) begin
                            // Outputs are set on the entry edge so they line up with the LOAD cycle.
                            state_q <= S_LOAD;
                            cnt_q   <= '0;
                            if (cap_q[10]) begin
                                clr_pulse_q <= 1'b1;
                                digit_cnt_q <= '0;
                                full_q      <= 1'b0;
                            end else if (digit_cnt_q < C_MAX) begin
                                loadn_q     <= 1'b0;
                                data_q      <= w_cap_idx;
                                digit_cnt_q <= digit_cnt_q + 2'd1;
                                full_q      <= ((digit_cnt_q + 2'd1) == C_MAX);
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_LOAD: begin
                        state_q <= S_WAIT_RELEASE;
                        cnt_q   <= '0;
                    end
                    S_WAIT_RELEASE: begin
                        if (pat_q != 11'd0) begin
                            cnt_q <= '0;
                        end else if ((cnt_q + 8'd1) >= C_DEB) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign data      = data_q;
    assign loadn     = loadn_q;
    assign digit_cnt = digit_cnt_q;
    assign full      = full_q;
    assign clr_pulse = clr_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_keypad_entry : directed scenarios plus random key traffic vs. a reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_keypad_entry;

    localparam int DEB  = 4;
    localparam int MAXD = 3;

    logic       clk       = 1'b0;
    logic       clrn      = 1'b1;
    logic [9:0] keys      = '0;
    logic       clear_key = 1'b0;
    logic       lock      = 1'b0;
    logic [3:0] data;
    logic       loadn;
    logic [1:0] digit_cnt;
    logic       full;
    logic       clr_pulse;

    keypad_entry #(.DEBOUNCE(DEB), .MAX_DIGITS(MAXD)) u_dut (
        .clk       (clk),
        .clrn      (clrn),
        .keys      (keys),
        .clear_key (clear_key),
        .lock      (lock),
        .data      (data),
        .loadn     (loadn),
        .digit_cnt (digit_cnt),
        .full      (full),
        .clr_pulse (clr_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw inputs reach the decision logic two samples late; a press
    // is a run of identical single-hot samples, accepted once it spans DEB+1 samples;
    // after acceptance the pad re-arms after DEB consecutive all-quiet samples.
    logic [10:0] m_s1, m_s2, m_run_pat;
    bit          m_armed, m_in_load;
    int          m_run, m_quiet, m_cnt;
    logic [3:0]  m_data;
    logic        m_loadn, m_clr, m_full;

    int          obs_strobes, obs_clrs;
    logic [11:0] obs_seq;

    function automatic int key_index(input logic [9:0] k);
        for (int i = 0; i < 10; i++) if (k[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_run_pat = '0;
        m_armed = 1'b1; m_in_load = 1'b0;
        m_run = 0; m_quiet = 0; m_cnt = 0;
        m_data = '0; m_loadn = 1'b1; m_clr = 1'b0; m_full = 1'b0;
    endtask

    task automatic model_step();
        logic [10:0] smp;
        smp = m_s2;
        if (!clrn) begin
            model_reset();
            return;
        end
        m_loadn = 1'b1;
        m_clr   = 1'b0;
        if (lock) begin
            m_armed = 1'b1; m_run = 0; m_in_load = 1'b0; m_quiet = 0;
        end else if (m_in_load) begin
            m_in_load = 1'b0; m_quiet = 0;
        end else if (!m_armed) begin
            m_quiet = (smp == 11'd0) ? m_quiet + 1 : 0;
            if (m_quiet == DEB) begin
                m_armed = 1'b1; m_quiet = 0;
            end
        end else if (m_run > 0) begin
            if (smp != m_run_pat) begin
                m_run = 0;
            end else if (m_run == DEB) begin
                m_run = 0; m_armed = 1'b0; m_in_load = 1'b1;
                if (m_run_pat[10]) begin
                    m_clr = 1'b1; m_cnt = 0; m_full = 1'b0;
                end else if (m_cnt < MAXD) begin
                    m_loadn = 1'b0;
                    m_data  = 4'(key_index(m_run_pat[9:0]));
                    m_cnt   = m_cnt + 1;
                    m_full  = (m_cnt == MAXD);
                end
            end else begin
                m_run = m_run + 1;
            end
        end else if ($countones(smp) == 1) begin
            m_run = 1; m_run_pat = smp;
        end
        m_s2 = m_s1;
        m_s1 = {clear_key, keys};
    endtask

    task automatic cycle(input logic [9:0] k, input logic c);
        keys = k;
        clear_key = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_value("loadn",     32'(loadn),     32'(m_loadn));
        check_value("data",      32'(data),      32'(m_data));
        check_value("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
        check_value("full",      32'(full),      32'(m_full));
        check_value("clr_pulse", 32'(clr_pulse), 32'(m_clr));
        if (loadn === 1'b0) begin
            obs_strobes++;
            obs_seq = {obs_seq[7:0], data};
        end
        if (clr_pulse === 1'b1) obs_clrs++;
    endtask

    task automatic press(input logic [9:0] k, input logic c, input int hold, input int gap);
        for (int i = 0; i < hold; i++) cycle(k, c);
        for (int i = 0; i < gap; i++) cycle(10'd0, 1'b0);
    endtask

    task automatic clear_obs();
        obs_strobes = 0;
        obs_clrs    = 0;
        obs_seq     = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check_value({tag, "_loadn"}, 32'(loadn),     32'd1);
        check_value({tag, "_data"},  32'(data),      32'd0);
        check_value({tag, "_cnt"},   32'(digit_cnt), 32'd0);
        check_value({tag, "_full"},  32'(full),      32'd0);
        check_value({tag, "_clr"},   32'(clr_pulse), 32'd0);
    endtask

    initial begin
        logic [9:0] k;
        int         sel;
        model_reset();
        clear_obs();
        #1 clrn = 1'b0;
        #2 check_reset_values("reset");
        @(negedge clk);
        cycle(10'd0, 1'b0);
        cycle(10'd0, 1'b0);
        clrn = 1'b1;
        cycle(10'd0, 1'b0);

        // Three digits 4, 3, 2 fill the entry.
        clear_obs();
        press(10'b1 << 4, 1'b0, 20, 10);
        check_value("d1_cnt", 32'(digit_cnt), 32'd1);
        press(10'b1 << 3, 1'b0, 20, 10);
        check_value("d2_cnt", 32'(digit_cnt), 32'd2);
        press(10'b1 << 2, 1'b0, 20, 10);
        check_value("fill_strobes", 32'(obs_strobes), 32'd3);
        check_value("fill_seq",     32'(obs_seq),     32'h432);
        check_value("fill_cnt",     32'(digit_cnt),   32'd3);
        check_value("fill_full",    32'(full),        32'd1);

        // A fourth digit is ignored once full.
        clear_obs();
        press(10'b1 << 9, 1'b0, 20, 10);
        check_value("over_strobes", 32'(obs_strobes), 32'd0);
        check_value("over_data",    32'(data),        32'd2);
        check_value("over_cnt",     32'(digit_cnt),   32'd3);

        clear_obs();
        press(10'd0, 1'b1, 10, 10);
        check_value("clr3_pulses", 32'(obs_clrs),  32'd1);
        check_value("clr3_cnt",    32'(digit_cnt), 32'd0);

        // Bouncing key 5 then stable.
        clear_obs();
        for (int r = 0; r < 5; r++) begin
            press(10'b1 << 5, 1'b0, 2, 0);
            if (r < 4) press(10'd0, 1'b0, 2, 0);
        end
        press(10'b1 << 5, 1'b0, 10, 10);
        check_value("bounce_strobes", 32'(obs_strobes), 32'd1);
        check_value("bounce_data",    32'(data),        32'd5);

        // Clear with two digits held for 10 cycles.
        press(10'b1 << 0, 1'b0, 20, 10);
        check_value("pre_clr_cnt", 32'(digit_cnt), 32'd2);
        clear_obs();
        press(10'd0, 1'b1, 10, 10);
        check_value("clr_pulses",  32'(obs_clrs),    32'd1);
        check_value("clr_cnt",     32'(digit_cnt),   32'd0);
        check_value("clr_full",    32'(full),        32'd0);
        check_value("clr_strobes", 32'(obs_strobes), 32'd0);

        // Two keys together are rejected; a following single key still works.
        clear_obs();
        press((10'b1 << 1) | (10'b1 << 7), 1'b0, 20, 10);
        check_value("multi_strobes", 32'(obs_strobes), 32'd0);
        press(10'b1 << 6, 1'b0, 20, 10);
        check_value("after_multi_strobes", 32'(obs_strobes), 32'd1);
        check_value("after_multi_data",    32'(data),        32'd6);

        // Lock blocks keys and clear.
        clear_obs();
        lock = 1'b1;
        press(10'b1 << 3, 1'b0, 20, 10);
        press(10'd0, 1'b1, 20, 10);
        lock = 1'b0;
        press(10'd0, 1'b0, 5, 0);
        check_value("lock_strobes", 32'(obs_strobes), 32'd0);
        check_value("lock_clrs",    32'(obs_clrs),    32'd0);
        check_value("lock_data",    32'(data),        32'd6);
        check_value("lock_cnt",     32'(digit_cnt),   32'd1);

        // Key held across lock release counts as a fresh press.
        clear_obs();
        lock = 1'b1;
        press(10'b1 << 2, 1'b0, 10, 0);
        lock = 1'b0;
        press(10'b1 << 2, 1'b0, 12, 10);
        check_value("unlock_strobes", 32'(obs_strobes), 32'd1);
        check_value("unlock_data",    32'(data),        32'd2);

        // Reset during debounce of key 8 aborts with no strobe.
        clear_obs();
        press(10'b1 << 8, 1'b0, 4, 0);
        clrn = 1'b0;
        #1 check_reset_values("abort");
        cycle(10'd0, 1'b0);
        cycle(10'd0, 1'b0);
        clrn = 1'b1;
        press(10'd0, 1'b0, 10, 0);
        check_value("abort_strobes", 32'(obs_strobes), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            k = 10'b1 << $urandom_range(0, 9);
            if (sel <= 5) begin
                press(k, 1'b0, int'($urandom_range(1, 12)), int'($urandom_range(0, 8)));
            end else if (sel == 6) begin
                press(10'd0, 1'b1, int'($urandom_range(1, 12)), int'($urandom_range(0, 8)));
            end else if (sel == 7) begin
                press(k | 10'(1 << $urandom_range(0, 9)), $urandom_range(0, 1) == 1,
                      int'($urandom_range(1, 12)), int'($urandom_range(0, 8)));
            end else if (sel == 8) begin
                press(k, 1'b0, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
            end else begin
                lock = ~lock;
                press(k, 1'b0, int'($urandom_range(1, 10)), int'($urandom_range(0, 6)));
            end
        end
        lock = 1'b0;
        press(10'd0, 1'b0, 10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
